// File: rtl/tfr_value_reader.sv
// Requester side of a toggle req/ack value transfer: pulls one sample from a foreign clock
// domain on demand and presents it as a valid/ready beat, abandoning dead requests on timeout.
module tfr_value_reader #(
   parameter int W       = 32,
   parameter int NFF     = 2,
   parameter int TIMEOUT = 1023
) (
   input  logic         i_clk,
   input  logic         i_reset_n,
   input  logic         i_rd_valid,
   output logic         o_rd_ready,
   output logic         o_req,
   input  logic         i_ack,
   input  logic [W-1:0] i_remote_data,
   output logic         o_valid,
   input  logic         i_ready,
   output logic [W-1:0] o_data,
   output logic         o_timeout
);

   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
   localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_OUT  = 2'd2;

   logic [NFF-1:0] r_ack_sync;
   logic [1:0]     r_state;
   logic           r_req;
   logic [CW-1:0]  r_cnt;
   logic           r_valid;
   logic [W-1:0]   r_data;
   logic           r_timeout;

   logic [1:0]     w_state_d;
   logic           w_req_d;
   logic [CW-1:0]  w_cnt_d;
   logic           w_valid_d;
   logic [W-1:0]   w_data_d;
   logic           w_timeout_d;
   logic           w_match;
   logic           w_rd_ready;

   // A mismatch after a timeout blocks new requests until the late ack is absorbed.
   assign w_match    = (r_ack_sync[NFF-1] == r_req);
   assign w_rd_ready = (r_state == S_IDLE) && w_match;

   always_comb begin
      w_state_d   = r_state;
      w_req_d     = r_req;
      w_cnt_d     = r_cnt;
      w_valid_d   = r_valid;
      w_data_d    = r_data;
      w_timeout_d = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_rd_valid && w_rd_ready) begin
               w_req_d   = ~r_req;
               w_cnt_d   = '0;
               w_state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            w_cnt_d = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;
            // Ack wins over timeout when both land on the same edge.
            if (w_match) begin
               w_data_d  = i_remote_data;
               w_valid_d = 1'b1;
               w_state_d = S_OUT;
            end else if ((TIMEOUT != 0) && (r_cnt == CNT_LAST)) begin
               w_timeout_d = 1'b1;
               w_state_d   = S_IDLE;
            end
         end
         S_OUT: begin
            if (i_ready) begin
               w_valid_d = 1'b0;
               w_state_d = S_IDLE;
            end
         end
         default: begin
            w_state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_ack_sync <= '0;
         r_state    <= S_IDLE;
         r_req      <= 1'b0;
         r_cnt      <= '0;
         r_valid    <= 1'b0;
         r_data     <= '0;
         r_timeout  <= 1'b0;
      end else begin
         r_ack_sync <= {r_ack_sync[NFF-2:0], i_ack};
         r_state    <= w_state_d;
         r_req      <= w_req_d;
         r_cnt      <= w_cnt_d;
         r_valid    <= w_valid_d;
         r_data     <= w_data_d;
         r_timeout  <= w_timeout_d;
      end
   end

   assign o_rd_ready = w_rd_ready;
   assign o_req      = r_req;
   assign o_valid    = r_valid;
   assign o_data     = r_data;
   assign o_timeout  = r_timeout;

endmodule

// File: tb/tb_tfr_value_reader.sv
// Directed bench for tfr_value_reader: loopback or manually driven remote ack, TIMEOUT=8.
module tb_tfr_value_reader;

   logic        clk;
   logic        reset_n;
   logic        rd_valid;
   logic        rd_ready;
   logic        req;
   logic        ack;
   logic        ack_man;
   logic        loop_en;
   logic [31:0] remote_data;
   logic        valid;
   logic        ready;
   logic [31:0] data;
   logic        tmo;

   int checks   = 0;
   int failures = 0;

   assign ack = loop_en ? req : ack_man;

   tfr_value_reader #(
      .W       (32),
      .NFF     (2),
      .TIMEOUT (8)
   ) dut (
      .i_clk         (clk),
      .i_reset_n     (reset_n),
      .i_rd_valid    (rd_valid),
      .o_rd_ready    (rd_ready),
      .o_req         (req),
      .i_ack         (ack),
      .i_remote_data (remote_data),
      .o_valid       (valid),
      .i_ready       (ready),
      .o_data        (data),
      .o_timeout     (tmo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: got %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      int n;
      int total;
      reset_n     = 1'b0;
      rd_valid    = 1'b0;
      ready       = 1'b0;
      loop_en     = 1'b0;
      ack_man     = 1'b0;
      remote_data = '0;

      // Reset with inputs toggling
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         rd_valid    = ~rd_valid;
         ack_man     = ~ack_man;
         ready       = ~ready;
         remote_data = $urandom;
      end
      @(negedge clk);
      chk1("rst_req", req, 1'b0);
      chk1("rst_valid", valid, 1'b0);
      chk32("rst_data", data, 32'h0);
      chk1("rst_timeout", tmo, 1'b0);
      rd_valid = 1'b0;
      ack_man  = 1'b0;
      ready    = 1'b0;
      reset_n  = 1'b1;
      @(negedge clk);
      chk1("rst_rd_ready", rd_ready, 1'b1);

      // Loopback single transfer
      loop_en     = 1'b1;
      ready       = 1'b1;
      remote_data = 32'hDEADBEEF;
      rd_valid    = 1'b1;
      @(negedge clk);  // k
      rd_valid = 1'b0;
      chk1("lb_req_k", req, 1'b1);
      chk1("lb_valid_k", valid, 1'b0);
      @(negedge clk);  // k+1
      chk1("lb_valid_k1", valid, 1'b0);
      @(negedge clk);  // k+2
      chk1("lb_valid_k2", valid, 1'b0);
      @(negedge clk);  // k+3
      chk1("lb_valid_k3", valid, 1'b1);
      chk32("lb_data_k3", data, 32'hDEADBEEF);
      chk1("lb_rd_ready_k3", rd_ready, 1'b0);
      @(negedge clk);  // k+4
      chk1("lb_valid_k4", valid, 1'b0);
      chk1("lb_rd_ready_k4", rd_ready, 1'b1);

      // Backpressure: held beat, changing remote data, ignored requests
      ready       = 1'b0;
      remote_data = 32'h11112222;
      rd_valid    = 1'b1;
      @(negedge clk);
      rd_valid = 1'b0;
      chk1("bp_req", req, 1'b0);
      n = 0;
      while (!valid && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk1("bp_valid_wait", valid, 1'b1);
      for (int i = 0; i < 10; i++) begin
         remote_data = $urandom;
         rd_valid    = 1'b1;
         @(negedge clk);
         chk1("bp_valid_held", valid, 1'b1);
         chk32("bp_data_held", data, 32'h11112222);
         chk1("bp_req_held", req, 1'b0);
      end
      rd_valid = 1'b0;
      ready    = 1'b1;
      @(negedge clk);
      chk1("bp_beat_done", valid, 1'b0);
      @(negedge clk);
      chk1("bp_one_beat", valid, 1'b0);
      chk1("bp_no_new_req", req, 1'b0);

      // Timeout with ack stuck at 0
      ack_man  = 1'b0;
      loop_en  = 1'b0;
      rd_valid = 1'b1;
      @(negedge clk);  // k
      rd_valid = 1'b0;
      chk1("to_req", req, 1'b1);
      for (int i = 1; i < 8; i++) begin
         @(negedge clk);
         chk1("to_no_pulse_early", tmo, 1'b0);
      end
      @(negedge clk);  // k+8
      chk1("to_pulse", tmo, 1'b1);
      chk1("to_no_valid", valid, 1'b0);
      chk1("to_rd_ready_low", rd_ready, 1'b0);
      @(negedge clk);  // k+9
      chk1("to_pulse_one_cycle", tmo, 1'b0);
      chk1("to_rd_ready_still_low", rd_ready, 1'b0);
      repeat (3) @(negedge clk);
      chk1("to_rd_ready_before_ack", rd_ready, 1'b0);
      ack_man = 1'b1;
      @(negedge clk);
      chk1("late_ack_sync1", rd_ready, 1'b0);
      @(negedge clk);
      chk1("late_ack_rd_ready", rd_ready, 1'b1);
      chk1("late_ack_no_valid", valid, 1'b0);
      @(negedge clk);
      chk1("late_ack_no_valid2", valid, 1'b0);
      chk32("late_ack_no_capture", data, 32'h11112222);

      // Ack match on the same edge as the timeout
      remote_data = 32'hCAFEF00D;
      rd_valid    = 1'b1;
      @(negedge clk);  // k
      rd_valid = 1'b0;
      chk1("mt_req", req, 1'b0);
      repeat (5) @(negedge clk);  // k+5
      ack_man = 1'b0;
      @(negedge clk);  // k+6
      @(negedge clk);  // k+7
      chk1("mt_valid_k7", valid, 1'b0);
      chk1("mt_tmo_k7", tmo, 1'b0);
      @(negedge clk);  // k+8
      chk1("mt_valid_k8", valid, 1'b1);
      chk1("mt_tmo_k8", tmo, 1'b0);
      chk32("mt_data_k8", data, 32'hCAFEF00D);
      @(negedge clk);  // k+9
      chk1("mt_tmo_k9", tmo, 1'b0);
      chk1("mt_valid_k9", valid, 1'b0);

      // Async reset in WAIT
      loop_en     = 1'b1;
      ready       = 1'b0;
      remote_data = 32'h5A5A5A5A;
      rd_valid    = 1'b1;
      @(negedge clk);
      rd_valid = 1'b0;
      chk1("arw_req_set", req, 1'b1);
      @(posedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      chk1("arw_req_clr", req, 1'b0);
      chk1("arw_valid_clr", valid, 1'b0);
      chk32("arw_data_clr", data, 32'h0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      chk1("arw_rd_ready", rd_ready, 1'b1);

      // Async reset in OUT
      rd_valid = 1'b1;
      @(negedge clk);
      rd_valid = 1'b0;
      n = 0;
      while (!valid && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk1("aro_valid_wait", valid, 1'b1);
      chk32("aro_data", data, 32'h5A5A5A5A);
      #2;
      reset_n = 1'b0;
      #1;
      chk1("aro_valid_clr", valid, 1'b0);
      chk32("aro_data_clr", data, 32'h0);
      chk1("aro_req_clr", req, 1'b0);
      @(negedge clk);
      reset_n = 1'b1;
      ready   = 1'b1;
      @(negedge clk);
      chk1("aro_rd_ready", rd_ready, 1'b1);

      // 100 back-to-back loopback transfers
      total = 0;
      for (int i = 0; i < 100; i++) begin
         n = 0;
         while (!rd_ready && n < 20) begin
            @(negedge clk);
            n++;
            total++;
         end
         chk1("b2b_rd_ready_wait", rd_ready, 1'b1);
         remote_data = 32'h1000_0000 + 32'(i);
         rd_valid    = 1'b1;
         @(negedge clk);
         total++;
         rd_valid = 1'b0;
         n = 0;
         while (!valid && n < 20) begin
            @(negedge clk);
            n++;
            total++;
         end
         chk1("b2b_valid_wait", valid, 1'b1);
         chk32("b2b_data", data, 32'h1000_0000 + 32'(i));
      end
      chk32("b2b_cycles", 32'(total), 32'd499);
      @(negedge clk);
      chk1("b2b_final_idle", valid, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
